// File: rtl/bridge_utils.sv
// Shared types for the AXI-read to APB bridge: responder command/status,
// captured AR fields, burst encodings and the read-sequencer state set.
package bridge_utils;

  typedef enum logic [1:0] {
    W_NOP      = 2'd0,
    W_GET_ADDR = 2'd1,
    W_GET_DATA = 2'd2
  } wr_cmd_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_BUSY   = 2'd1,
    W_SWITCH = 2'd2
  } wr_info_t;

  // addr is carried at 32 bits; the sequencer uses the low ADDR_WIDTH bits
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } addr_info_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_ADDR  = 3'd1,
    WAIT_ADDR = 3'd2,
    APB_REQ   = 3'd3,
    APB_WAIT  = 3'd4,
    RELEASE   = 3'd5,
    DRAIN     = 3'd6
  } rd_state_t;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Transfer size is clamped to 4 bytes; the reserved burst code behaves as INCR.
module axi_addr_gen
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [6:0]            incr_small;
  logic [6:0]            bound;
  logic [ADDR_WIDTH-1:0] bound_m1;
  logic [ADDR_WIDTH-1:0] incr_addr;

  always_comb begin
    case (size)
      3'd0:    incr_small = 7'd1;
      3'd1:    incr_small = 7'd2;
      default: incr_small = 7'd4;
    endcase
  end

  // bound is at most 16 beats * 4 bytes = 64, so 7 bits suffice
  assign bound     = ({3'b000, len} + 7'd1) * incr_small;
  assign bound_m1  = ADDR_WIDTH'(bound - 7'd1);
  assign incr_addr = addr + ADDR_WIDTH'(incr_small);

  always_comb begin
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~bound_m1) | (incr_addr & bound_m1);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/bridge_rd_sequencer.sv
// Read-path sequencer: fetches the AR fields from the responder, splits the
// burst into single APB reads, pushes each beat into the read FIFO, then hands back.
module bridge_rd_sequencer
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_grant,
  output logic                  rd_busy,
  output wr_cmd_t               wr_cmd,
  input  wr_info_t              wr_info,
  input  addr_info_t            addr_info,
  output logic                  apb_req,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  input  logic                  apb_done,
  input  logic                  apb_slverr,
  output logic                  fifo_write,
  input  logic                  fifo_full,
  output logic                  rd_slverr,
  output rd_state_t             dbg_state
);

  if (DATA_WIDTH != 32 || FIFO_DEPTH < 16) begin : g_param_check
    $error("bridge_rd_sequencer: DATA_WIDTH must be 32 and FIFO_DEPTH >= 16");
  end

  rd_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr, next_addr;
  logic [3:0]            len_q, beat_cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  capture, beat_done;

  // Handshake: apb_req is a request held high with apb_addr stable until the
  // single-cycle apb_done; the transfer is complete on that cycle and nothing else.
  assign capture   = (state == WAIT_ADDR) && (wr_info == W_SWITCH);
  assign beat_done = (state == APB_WAIT) && apb_done;

  axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .addr      (cur_addr),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_cnt  <= '0;
      rd_slverr <= 1'b0;
    end else if (capture) begin
      cur_addr  <= addr_info.addr[ADDR_WIDTH-1:0];
      len_q     <= addr_info.len;
      size_q    <= addr_info.size;
      burst_q   <= addr_info.burst;
      beat_cnt  <= '0;
      rd_slverr <= 1'b0;
    end else if (beat_done) begin
      cur_addr  <= next_addr;
      beat_cnt  <= beat_cnt + 4'd1;
      rd_slverr <= rd_slverr | apb_slverr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (rd_grant && (wr_info == W_IDLE)) state_nxt = GET_ADDR;
      GET_ADDR:  state_nxt = WAIT_ADDR;
      WAIT_ADDR: if (wr_info == W_SWITCH) state_nxt = APB_REQ;
      APB_REQ:   if (!fifo_full) state_nxt = APB_WAIT;
      APB_WAIT:  if (apb_done) state_nxt = (beat_cnt == len_q) ? RELEASE : APB_REQ;
      RELEASE:   state_nxt = DRAIN;
      DRAIN:     if (wr_info == W_IDLE) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_cmd     = W_NOP;
    apb_req    = 1'b0;
    fifo_write = 1'b0;
    case (state)
      GET_ADDR: wr_cmd = W_GET_ADDR;
      APB_REQ:  apb_req = !fifo_full;
      APB_WAIT: begin
        apb_req    = 1'b1;
        fifo_write = apb_done;
      end
      RELEASE:  wr_cmd = W_GET_DATA;
      default:  ;
    endcase
  end

  assign apb_addr  = apb_req ? cur_addr : '0;
  assign rd_busy   = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/bridge_rd_sequencer.md
BRIDGE_RD_SEQUENCER -- requirements
Module: bridge_rd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of APB addresses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, read-data FIFO depth in beats; must be ≥16.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_grant  in  1  arbiter grant; read path may start a transaction.
- rd_busy  out  1  high from leaving IDLE until return to IDLE.
- wr_cmd  out  wr_cmd_t  command to the AXI read-channel responder.
- wr_info  in  wr_info_t  responder status: W_IDLE, W_BUSY or W_SWITCH.
- addr_info  in  addr_info_t  captured AR fields: addr, len, size, burst.
- apb_req  out  1  request one APB read transfer.
- apb_addr  out  ADDR_WIDTH  address for the current APB transfer.
- apb_done  in  1  one-cycle pulse; APB transfer completed.
- apb_slverr  in  1  PSLVERR qualified by apb_done.
- fifo_write  out  1  push APB read data into the read-data FIFO.
- fifo_full  in  1  read-data FIFO full.
- rd_slverr  out  1  sticky error for the current burst.

Function
REQ-005 States SHALL be IDLE, GET_ADDR, WAIT_ADDR, APB_REQ, APB_WAIT, RELEASE, DRAIN.
REQ-006 IDLE: wr_cmd=W_NOP; on rd_grant=1 and wr_info==W_IDLE, go to GET_ADDR.
REQ-007 GET_ADDR: wr_cmd=W_GET_ADDR for exactly one cycle, then go to WAIT_ADDR.
REQ-008 WAIT_ADDR: wait for wr_info==W_SWITCH.
  - On that cycle, latch addr_info into cur_addr, len, size and burst.
  - Clear the beat counter and rd_slverr.
  - Go to APB_REQ.
REQ-009 APB_REQ: if fifo_full=0, assert apb_req with apb_addr=cur_addr and go to APB_WAIT; otherwise stay with apb_req=0.
REQ-010 APB_WAIT: keep apb_req=1 and apb_addr stable until apb_done. On the apb_done cycle:
  - Assert fifo_write for that single cycle.
  - OR apb_slverr into rd_slverr.
  - Advance cur_addr and the beat counter.
REQ-011 After an apb_done, go to RELEASE if the beat counter equals len; otherwise go to APB_REQ. Minimum beat period is 2 cycles.
REQ-012 RELEASE: wr_cmd=W_GET_DATA for one cycle, then go to DRAIN.
REQ-013 DRAIN: wait for wr_info==W_IDLE, then go to IDLE. rd_slverr holds its value until the next WAIT_ADDR capture.
REQ-014 Next-address rules, with incr = 1<<size (size>2 clamped to 2):
  - FIXED: the address is unchanged.
  - INCR: cur_addr+incr, wrapping modulo 2^ADDR_WIDTH.
  - WRAP: bound=(len+1)*incr; next=(cur_addr & ~(bound-1)) | ((cur_addr+incr) & (bound-1)).
  - Reserved burst=2'b11 is treated as INCR.
REQ-015 The beat counter SHALL be 4 bits, zero-based, supporting 1–16 beats; len=0 yields exactly one APB transfer.
REQ-016 apb_done outside APB_WAIT SHALL be ignored.
REQ-017 fifo_full asserted during APB_WAIT SHALL NOT abort the transfer; the FIFO reserves one beat.
REQ-018 rd_grant deasserted after leaving IDLE SHALL NOT abort; the burst completes.
REQ-019 rd_busy SHALL equal (state != IDLE), driven combinationally.
REQ-020 An unreachable state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-021 On rst_n=0 (asynchronous), the block SHALL enter IDLE and zero cur_addr, len, size, burst, the beat counter and rd_slverr.
REQ-022 Output reset values SHALL be: wr_cmd=W_NOP, apb_req=0, apb_addr=0, fifo_write=0, rd_busy=0, rd_slverr=0.
REQ-023 Reset mid-burst SHALL discard the burst; no fifo_write may follow reset release until a new apb_done in APB_WAIT.

Structure
REQ-024 The following SHALL live in bridge_utils:
  - wr_cmd_t (W_NOP, W_GET_ADDR, W_GET_DATA).
  - wr_info_t.
  - addr_info_t.
  - burst encodings BURST_FIXED=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10.
REQ-025 Next-address computation SHALL be a combinational sub-module axi_addr_gen (inputs addr, len, size, burst; output next_addr); all else is inline.

Verification
REQ-026 INCR, addr=0x1000, len=3, size=2:
  - apb_addr sequence is 0x1000, 0x1004, 0x1008, 0x100C.
  - 4 fifo_write pulses, then one W_GET_DATA, rd_slverr=0.
REQ-027 WRAP, addr=0x1008, len=3, size=2 → apb_addr sequence 0x1008, 0x100C, 0x1000, 0x1004.
REQ-028 FIXED, addr=0x2000, len=15 → 16 transfers all at 0x2000; the beat counter wraps to 0 with no 17th transfer.
REQ-029 Flow control:
  - fifo_full=1 before beat 2 of a len=3 INCR burst → apb_req stays 0 while full.
  - Resumes one cycle after fifo_full=0 with the correct address.
REQ-030 apb_slverr=1 on beat 1 of a len=2 burst → all 3 beats complete and rd_slverr=1 until the next WAIT_ADDR.
REQ-031 rst_n pulsed low during APB_WAIT of beat 2 → all outputs take reset values immediately; no fifo_write after release; the next grant starts cleanly.
